// File: rtl/k054000_pkg.sv
// rtl/k054000_pkg.sv - register offsets, status offset and FSM state encoding
package k054000_pkg;

   // Multi-byte values are stored MSB at the lowest offset
   localparam logic [4:0] OFS_AX     = 5'h00;
   localparam logic [4:0] OFS_AY     = 5'h03;
   localparam logic [4:0] OFS_AW     = 5'h06;
   localparam logic [4:0] OFS_AH     = 5'h07;
   localparam logic [4:0] OFS_BX     = 5'h08;
   localparam logic [4:0] OFS_BY     = 5'h0B;
   localparam logic [4:0] OFS_BW     = 5'h0E;
   localparam logic [4:0] OFS_BH     = 5'h0F;
   localparam logic [4:0] OFS_DX     = 5'h10;
   localparam logic [4:0] OFS_DY     = 5'h11;
   localparam logic [4:0] OFS_LAST   = 5'h11;
   localparam logic [4:0] OFS_STATUS = 5'h18;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EVAL_X = 2'd1,
      ST_EVAL_Y = 2'd2
   } state_t;

endpackage

// File: rtl/k054000_seq_if.sv
// rtl/k054000_seq_if.sv - host register bus between CPU side and the collision sequencer
interface k054000_seq_if;
   logic       nCS;
   logic       nWR;
   logic       nRD;
   logic [4:0] ADDR;
   logic [7:0] DIN;
   logic [7:0] DOUT;

   modport master (output nCS, nWR, nRD, ADDR, DIN, input DOUT);
   modport slave  (input nCS, nWR, nRD, ADDR, DIN, output DOUT);
endinterface

// File: rtl/k054000_unit.sv
// rtl/k054000_unit.sv - single-axis box separation comparator
module k054000_unit (
   input  logic [23:0] i_pos_a,
   input  logic [23:0] i_pos_b,
   input  logic [7:0]  i_size_a,
   input  logic [7:0]  i_size_b,
   input  logic [7:0]  i_delta,
   output logic        o_apart
);

   logic [23:0] w_diff;
   logic [23:0] w_mag;
   logic [8:0]  w_sum;

   // Signed distance wraps modulo 2^24; magnitude is taken on the wrapped value
   assign w_diff  = i_pos_a + {{16{i_delta[7]}}, i_delta} - i_pos_b;
   assign w_mag   = w_diff[23] ? (24'd0 - w_diff) : w_diff;
   assign w_sum   = {1'b0, i_size_a} + {1'b0, i_size_b};
   // Far out of range, or not closer than the combined extent
   assign o_apart = (w_mag > 24'h0001FF) || (w_mag[8:0] >= w_sum);

endmodule

// File: rtl/k054000_seq.sv
// rtl/k054000_seq.sv - register file, evaluation FSM and status read for the collision checker
module k054000_seq
   import k054000_pkg::*;
(
   input  logic                CLK,
   input  logic                nRES,
   k054000_seq_if.slave        bus,
   output logic                BUSY,
   output logic                HIT
);

   logic [23:0] r_ax, r_ay, r_bx, r_by;
   logic [7:0]  r_aw, r_ah, r_bw, r_bh, r_dx, r_dy;
   logic        r_wr_act;
   logic        r_x_apart;
   logic        r_hit;
   state_t      r_state;
   state_t      w_state_nxt;

   logic        w_wr_act;
   logic        w_wr_acc;
   logic        w_start;
   logic [23:0] w_pos_a, w_pos_b;
   logic [7:0]  w_size_a, w_size_b, w_delta;
   logic        w_apart;

   assign w_wr_act = ~bus.nCS & ~bus.nWR;
   assign w_wr_acc = w_wr_act & ~r_wr_act;
   assign w_start  = w_wr_acc && (bus.ADDR <= OFS_LAST);

   // Strobe history so a held write is taken only once
   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) r_wr_act <= 1'b0;
      else       r_wr_act <= w_wr_act;
   end

   // Write-only register file
   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         r_ax <= '0; r_ay <= '0; r_bx <= '0; r_by <= '0;
         r_aw <= '0; r_ah <= '0; r_bw <= '0; r_bh <= '0;
         r_dx <= '0; r_dy <= '0;
      end else if (w_wr_acc) begin
         case (bus.ADDR)
            OFS_AX:         r_ax[23:16] <= bus.DIN;
            OFS_AX + 5'd1:  r_ax[15:8]  <= bus.DIN;
            OFS_AX + 5'd2:  r_ax[7:0]   <= bus.DIN;
            OFS_AY:         r_ay[23:16] <= bus.DIN;
            OFS_AY + 5'd1:  r_ay[15:8]  <= bus.DIN;
            OFS_AY + 5'd2:  r_ay[7:0]   <= bus.DIN;
            OFS_AW:         r_aw        <= bus.DIN;
            OFS_AH:         r_ah        <= bus.DIN;
            OFS_BX:         r_bx[23:16] <= bus.DIN;
            OFS_BX + 5'd1:  r_bx[15:8]  <= bus.DIN;
            OFS_BX + 5'd2:  r_bx[7:0]   <= bus.DIN;
            OFS_BY:         r_by[23:16] <= bus.DIN;
            OFS_BY + 5'd1:  r_by[15:8]  <= bus.DIN;
            OFS_BY + 5'd2:  r_by[7:0]   <= bus.DIN;
            OFS_BW:         r_bw        <= bus.DIN;
            OFS_BH:         r_bh        <= bus.DIN;
            OFS_DX:         r_dx        <= bus.DIN;
            OFS_DY:         r_dy        <= bus.DIN;
            default:        ;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state: any mapped write restarts the evaluation from the X axis
   always_comb begin
      w_state_nxt = r_state;
      if (w_start) begin
         w_state_nxt = ST_EVAL_X;
      end else begin
         case (r_state)
            ST_IDLE:   w_state_nxt = ST_IDLE;
            ST_EVAL_X: w_state_nxt = ST_EVAL_Y;
            ST_EVAL_Y: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Operand mux feeding the shared comparator
   always_comb begin
      w_pos_a  = r_ax;
      w_pos_b  = r_bx;
      w_size_a = r_aw;
      w_size_b = r_bw;
      w_delta  = r_dx;
      if (r_state == ST_EVAL_Y) begin
         w_pos_a  = r_ay;
         w_pos_b  = r_by;
         w_size_a = r_ah;
         w_size_b = r_bh;
         w_delta  = r_dy;
      end
   end

   k054000_unit u_unit (
      .i_pos_a  (w_pos_a),
      .i_pos_b  (w_pos_b),
      .i_size_a (w_size_a),
      .i_size_b (w_size_b),
      .i_delta  (w_delta),
      .o_apart  (w_apart)
   );

   // Result capture; an aborting write suppresses both latches so HIT keeps its old value
   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         r_x_apart <= 1'b1;
         r_hit     <= 1'b0;
      end else if (!w_start) begin
         if (r_state == ST_EVAL_X) r_x_apart <= w_apart;
         if (r_state == ST_EVAL_Y) r_hit     <= ~(r_x_apart | w_apart);
      end
   end

   assign BUSY     = (r_state != ST_IDLE);
   assign HIT      = r_hit;
   assign bus.DOUT = (!bus.nCS && !bus.nRD && bus.ADDR == OFS_STATUS) ?
                     {BUSY, 6'b0, ~r_hit} : 8'h00;

endmodule

// File: doc/k054000_seq.md
K054000_SEQ -- requirements
Module: k054000_seq

Interface
REQ-001 Ports SHALL be, clock and reset first:
- CLK  in  1  single system clock; all state updates on rising edge.
- nRES  in  1  asynchronous, active-low reset.
- nCS  in  1  chip select, active low.
- nWR  in  1  write strobe, active low.
- nRD  in  1  read strobe, active low.
- ADDR  in  5  register offset.
- DIN  in  8  write data.
- DOUT  out  8  read data.
- BUSY  out  1  evaluation in progress.
- HIT  out  1  registered collision flag: 1 = boxes overlap on both axes.

REQ-002 Parameters: none.

Function
REQ-003 Register map, write-only, multi-byte values most-significant byte at the lowest offset:
- 0x00-0x02 A_X[23:0]; 0x03-0x05 A_Y[23:0]
- 0x06 A_W[7:0]; 0x07 A_H[7:0]
- 0x08-0x0A B_X[23:0]; 0x0B-0x0D B_Y[23:0]
- 0x0E B_W[7:0]; 0x0F B_H[7:0]
- 0x10 DX[7:0]; 0x11 DY[7:0], both signed.
- Other offsets: writes SHALL be ignored.
REQ-004 A write SHALL be accepted only in the first cycle in which nCS=0 and nWR=0, i.e. on the falling-edge detect of (nCS|nWR). A held strobe SHALL yield exactly one write.
REQ-005 Read data:
- nCS=0, nRD=0, ADDR=0x18: DOUT SHALL be combinationally {BUSY, 6'b0, ~HIT}.
- Any other offset, or no read strobe: DOUT SHALL be 0x00.
REQ-006 FSM states IDLE, EVAL_X, EVAL_Y.
- An accepted write to a mapped offset SHALL move the FSM to EVAL_X on the next edge, from any state.
- EVAL_X SHALL go to EVAL_Y; EVAL_Y SHALL go to IDLE.
REQ-007 BUSY SHALL equal (state != IDLE), registered.
REQ-008 One comparator SHALL be time-multiplexed across the two axes:
- EVAL_X operands: pos A=A_X, pos B=B_X, size A=A_W, size B=B_W, delta=DX.
- EVAL_Y operands: A_Y, B_Y, A_H, B_H, DY.
REQ-009 Axis "apart" flag:
- Set when |A+sext(delta)-B| (24-bit, modulo 2^24) is not within 0x1FF, or when the 9-bit magnitude is >= size A + size B (9-bit sum, no overflow).
- The last test is exactly the comparator's result.
REQ-010 Result timing:
- The X apart flag SHALL be latched at the EVAL_X->EVAL_Y edge.
- HIT SHALL be updated to ~(X_apart | Y_apart) at the EVAL_Y->IDLE edge.
- HIT SHALL therefore be valid and BUSY=0 exactly 3 edges after the write-accept edge.
REQ-011 A write accepted during EVAL_X or EVAL_Y SHALL abort the evaluation. The FSM SHALL restart at EVAL_X and HIT SHALL keep its previous value.
REQ-012 While BUSY=1, reads SHALL return the previous HIT with bit7 set.
REQ-013 Simultaneous nWR=0 and nRD=0: the write SHALL be accepted, and DOUT SHALL reflect the pre-write status.

Reset
REQ-014 On nRES=0, asynchronously:
- All data registers SHALL go to 0.
- State SHALL go to IDLE; BUSY=0; HIT=0.
- The X latch SHALL go to 1.
- The strobe-edge history SHALL go to "inactive".
REQ-015 Reset asserted mid-evaluation SHALL discard the evaluation; no HIT update SHALL occur after release until a new write.

Structure
REQ-016 Package k054000_pkg SHALL hold the register offset constants, the status offset 0x18, and the FSM state enum.
REQ-017 Exactly one instance of the combinational collision comparator k054000_unit SHALL be used, with operands muxed by state.

Verification
REQ-018 Reset then read 0x18 -> DOUT=0x01, BUSY=0, HIT=0.
REQ-019 X-axis overlap case:
- Stimulus: A_X=0x000100, B_X=0x000108, A_W=B_W=0x10, DX=0; Y registers equal, A_H=B_H=0x10.
- Required: 3 edges after the last write, HIT=1 and DOUT=0x00.
REQ-020 Same setup with B_X=0x000140 (gap 64 >= 32) -> HIT=0, DOUT=0x01. B_X=0x010000 -> HIT=0 via the range test.
REQ-021 Write A_Y while in EVAL_Y -> BUSY stays 1 for 3 further edges, and HIT keeps its old value until then.
REQ-022 Hold nCS=nWR=0 for 5 cycles at offset 0x06 -> one write accepted, and BUSY deasserts 3 edges after the first cycle.
REQ-023 Assert nRES during EVAL_X -> BUSY=0 and HIT=0 immediately, with no later HIT change.
